// File: rtl/histogram_pkg.sv
// histogram_pkg: shared types, constants and helpers for the pipelined histogram engine.
//   state_e      - control FSM states
//   DRAIN_CYCLES - cycles spent flushing the S1/S2 pipeline after the last pixel issue
//   bin_slice()  - maps a pixel value to its bin index (top BIN_ADDR_WIDTH bits)
package histogram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned DRAIN_CYCLES = 2;

  // Widest pixel the slice helper handles.
  localparam int unsigned SLICE_MAX_W = 32;

  // Upper bin_w bits of a pix_w-wide pixel, right-aligned.
  function automatic logic [SLICE_MAX_W-1:0] bin_slice(
    input logic [SLICE_MAX_W-1:0] pix,
    input int unsigned            pix_w,
    input int unsigned            bin_w
  );
    logic [SLICE_MAX_W-1:0] mask;
    mask = (SLICE_MAX_W'(1) << bin_w) - SLICE_MAX_W'(1);
    return (pix >> (pix_w - bin_w)) & mask;
  endfunction

endpackage

// File: rtl/histogram_bin_update.sv
// histogram_bin_update: S2 read-modify-write datapath.
// Selects the base count (forwarded last write or RAM read data), increments it
// and remembers the write for the next cycle's hazard check.
//   clk, rst   - clock, asynchronous active-high reset
//   i_s2_vld   - S2 holds a valid pixel this cycle
//   i_bin      - S2 bin index
//   i_rdata    - bin RAM read data for i_bin (stale if written last cycle)
//   o_wdata_c  - updated count (combinational)
// Optional: `HISTOGRAM_SATURATE_EN` makes the counter stick at all-ones instead of wrapping.
module histogram_bin_update
  import histogram_pkg::*;
#(
  parameter int unsigned BIN_ADDR_WIDTH = 8,
  parameter int unsigned BIN_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_s2_vld,
  input  logic [BIN_ADDR_WIDTH-1:0] i_bin,
  input  logic [BIN_WIDTH-1:0]      i_rdata,
  output logic [BIN_WIDTH-1:0]      o_wdata_c
);

  logic                      r_last_vld;
  logic [BIN_ADDR_WIDTH-1:0] r_last_bin;
  logic [BIN_WIDTH-1:0]      r_last_data;

  logic                      w_fwd;
  logic [BIN_WIDTH-1:0]      w_base;
  logic [BIN_WIDTH-1:0]      w_next;

  // The RAM returns old data when the same bin was written one cycle ago,
  // so the previous write is forwarded in that case.
  always_comb begin
    w_fwd  = r_last_vld && (r_last_bin == i_bin);
    w_base = w_fwd ? r_last_data : i_rdata;
`ifdef HISTOGRAM_SATURATE_EN
    w_next = (w_base == '1) ? w_base : w_base + BIN_WIDTH'(1);
`else
    w_next = w_base + BIN_WIDTH'(1);
`endif
  end

  assign o_wdata_c = w_next;

  // Previous-write register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_vld  <= 1'b0;
      r_last_bin  <= '0;
      r_last_data <= '0;
    end else begin
      r_last_vld <= i_s2_vld;
      if (i_s2_vld) begin
        r_last_bin  <= i_bin;
        r_last_data <= w_next;
      end
    end
  end

endmodule

// File: rtl/histogram_pipelined.sv
// histogram_pipelined: II=1 histogram engine over external pixel and bin RAMs.
// Optionally zeroes every bin, then streams NUM_PIXELS pixels through a 3-stage
// pipeline (S0 address issue, S1 bin lookup, S2 increment/write).
//   clk, rst        - clock, asynchronous active-high reset
//   start, clear    - run request (accepted in IDLE/DONE), clear-bins-first flag
//   valid           - high while in DONE
//   arg_0_raddr_0   - pixel RAM read address (registered), arg_0_rdata_0 1-cycle data
//   arg_1_raddr_0   - bin RAM read address, arg_1_rdata_0 1-cycle data (old on RdW)
//   arg_1_waddr_0/wdata_0/wen_0 - bin RAM write port
// Optional: define `HISTOGRAM_SATURATE_EN` to saturate bin counts instead of wrapping.
module histogram_pipelined
  import histogram_pkg::*;
#(
  parameter int unsigned PIX_WIDTH      = 8,
  parameter int unsigned PIX_ADDR_WIDTH = 12,
  parameter int unsigned NUM_PIXELS     = 4096,
  parameter int unsigned BIN_ADDR_WIDTH = 8,
  parameter int unsigned BIN_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clear,
  output logic                      valid,
  output logic [PIX_ADDR_WIDTH-1:0] arg_0_raddr_0,
  input  logic [PIX_WIDTH-1:0]      arg_0_rdata_0,
  output logic [BIN_ADDR_WIDTH-1:0] arg_1_raddr_0,
  input  logic [BIN_WIDTH-1:0]      arg_1_rdata_0,
  output logic [BIN_ADDR_WIDTH-1:0] arg_1_waddr_0,
  output logic [BIN_WIDTH-1:0]      arg_1_wdata_0,
  output logic                      arg_1_wen_0
);

  localparam int unsigned DRAIN_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [PIX_ADDR_WIDTH-1:0] LAST_PIX   = PIX_ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [BIN_ADDR_WIDTH-1:0] LAST_BIN   = '1;
  localparam logic [DRAIN_CNT_W-1:0]    LAST_DRAIN = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  state_e                    r_state;
  state_e                    w_next_state;

  logic                      r_valid;
  logic [PIX_ADDR_WIDTH-1:0] r_pix_addr;
  logic [BIN_ADDR_WIDTH-1:0] r_clr_addr;
  logic [DRAIN_CNT_W-1:0]    r_drain_cnt;

  logic                      r_s1_vld;
  logic                      r_s2_vld;
  logic [BIN_ADDR_WIDTH-1:0] r_s2_bin;

  logic [BIN_ADDR_WIDTH-1:0] w_s1_bin;
  logic [BIN_WIDTH-1:0]      w_upd_wdata;

  // Next-state logic; start/clear only matter in IDLE or DONE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next_state = clear ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        if (r_clr_addr == LAST_BIN) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (r_pix_addr == LAST_PIX) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == LAST_DRAIN) w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, counters and S1/S2 valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_pix_addr  <= '0;
      r_clr_addr  <= '0;
      r_drain_cnt <= '0;
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s2_bin    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_valid     <= (w_next_state == ST_DONE);
      r_clr_addr  <= (r_state == ST_CLEAR) ? r_clr_addr + BIN_ADDR_WIDTH'(1) : '0;
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRAIN_CNT_W'(1) : '0;
      // Pixel address is zero outside RUN, so it reads as 0 when inactive
      // and starts at 0 on the first RUN cycle.
      if ((r_state == ST_RUN) && (w_next_state == ST_RUN)) begin
        r_pix_addr <= r_pix_addr + PIX_ADDR_WIDTH'(1);
      end else begin
        r_pix_addr <= '0;
      end
      r_s1_vld <= (r_state == ST_RUN);
      r_s2_vld <= r_s1_vld;
      r_s2_bin <= w_s1_bin;
    end
  end

  // S1: pixel data is back this cycle; its bin index addresses the bin RAM directly.
  assign w_s1_bin = r_s1_vld
                  ? BIN_ADDR_WIDTH'(bin_slice(SLICE_MAX_W'(arg_0_rdata_0), PIX_WIDTH, BIN_ADDR_WIDTH))
                  : '0;

  histogram_bin_update #(
    .BIN_ADDR_WIDTH (BIN_ADDR_WIDTH),
    .BIN_WIDTH      (BIN_WIDTH)
  ) u_bin_update (
    .clk       (clk),
    .rst       (rst),
    .i_s2_vld  (r_s2_vld),
    .i_bin     (r_s2_bin),
    .i_rdata   (arg_1_rdata_0),
    .o_wdata_c (w_upd_wdata)
  );

  // Write port is shared between the clear sweep and the S2 increment;
  // the two never overlap in time.
  assign arg_1_wen_0   = (r_state == ST_CLEAR) || r_s2_vld;
  assign arg_1_waddr_0 = (r_state == ST_CLEAR) ? r_clr_addr
                       : (r_s2_vld ? r_s2_bin : '0);
  assign arg_1_wdata_0 = r_s2_vld ? w_upd_wdata : '0;

  assign arg_0_raddr_0 = r_pix_addr;
  assign arg_1_raddr_0 = w_s1_bin;
  assign valid         = r_valid;

endmodule

// File: tb/tb_histogram_pipelined.sv
// tb_histogram_pipelined: directed + randomized bench with behavioural RAM models
// and an arithmetic histogram reference.
module tb_histogram_pipelined;

  localparam int unsigned PW    = 8;
  localparam int unsigned PAW   = 4;
  localparam int unsigned NP    = 8;
  localparam int unsigned BAW   = 4;
  localparam int unsigned BW    = 4;
  localparam int          NBINS = 1 << BAW;
  localparam int          SHIFT = PW - BAW;
  localparam int          BMAX  = (1 << BW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           clear = 1'b0;
  logic           valid;
  logic [PAW-1:0] pix_raddr;
  logic [PW-1:0]  pix_rdata;
  logic [BAW-1:0] bin_raddr;
  logic [BW-1:0]  bin_rdata;
  logic [BAW-1:0] bin_waddr;
  logic [BW-1:0]  bin_wdata;
  logic           bin_wen;

  histogram_pipelined #(
    .PIX_WIDTH      (PW),
    .PIX_ADDR_WIDTH (PAW),
    .NUM_PIXELS     (NP),
    .BIN_ADDR_WIDTH (BAW),
    .BIN_WIDTH      (BW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .clear         (clear),
    .valid         (valid),
    .arg_0_raddr_0 (pix_raddr),
    .arg_0_rdata_0 (pix_rdata),
    .arg_1_raddr_0 (bin_raddr),
    .arg_1_rdata_0 (bin_rdata),
    .arg_1_waddr_0 (bin_waddr),
    .arg_1_wdata_0 (bin_wdata),
    .arg_1_wen_0   (bin_wen)
  );

  always #5 clk = ~clk;

  // RAM models: 1-cycle read, read-during-write returns old data.
  logic [PW-1:0] pix_mem [1 << PAW];
  logic [BW-1:0] bin_mem [NBINS];
  logic [BW-1:0] preset  [NBINS];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    pix_rdata <= pix_mem[pix_raddr];
    bin_rdata <= bin_mem[bin_raddr];
    if (load_req) begin
      for (int i = 0; i < NBINS; i++) bin_mem[i] <= preset[i];
    end else if (bin_wen) begin
      bin_mem[bin_waddr] <= bin_wdata;
    end
  end

  // Cycle counter and write monitor.
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr = -1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bin_wen) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_bins [NBINS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int bump(input int v);
`ifdef HISTOGRAM_SATURATE_EN
    return (v == BMAX) ? v : v + 1;
`else
    return (v + 1) % (BMAX + 1);
`endif
  endfunction

  // Load bin RAM with preset[] and mirror it in the model.
  task automatic load_bins();
    for (int b = 0; b < NBINS; b++) exp_bins[b] = int'(preset[b]);
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic preset_random();
    for (int b = 0; b < NBINS; b++) preset[b] = BW'($urandom_range(0, BMAX));
    load_bins();
  endtask

  task automatic preset_const(input int v);
    for (int b = 0; b < NBINS; b++) preset[b] = BW'(v);
    load_bins();
  endtask

  function automatic logic [PW-1:0] pix_of_bin(input int b);
    logic [PW-1:0] p;
    p = PW'($urandom_range(0, (1 << SHIFT) - 1));
    p = p | PW'(b << SHIFT);
    return p;
  endfunction

  // One run: model update, start, wait for valid, then timing/count/content checks.
  task automatic run_check(input bit do_clear, input bit poke, input string tag);
    int t0, w0, vcyc, base;
    bit seen;
    if (do_clear) for (int b = 0; b < NBINS; b++) exp_bins[b] = 0;
    for (int i = 0; i < NP; i++) begin
      int b;
      b = int'(pix_mem[i]) >> SHIFT;
      exp_bins[b] = bump(exp_bins[b]);
    end
    base = do_clear ? NBINS : 0;

    @(negedge clk);
    start = 1'b1;
    clear = do_clear;
    t0 = cyc;
    w0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (poke) begin
        start = (k == 3);
        clear = (k == 3);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    clear = 1'b0;
    vcyc = seen ? (cyc - t0) : -1;
    chk({tag, "_valid_cycle"}, 32'(vcyc), 32'(base + NP + 3));
    chk({tag, "_last_write"}, 32'(last_wr - t0), 32'(base + NP + 2));
    chk({tag, "_write_count"}, 32'(wr_cnt - w0), 32'(base + NP));
    chk({tag, "_done_outputs"},
        32'({bin_wen, pix_raddr, bin_raddr, bin_waddr, bin_wdata}), 32'd0);
    for (int b = 0; b < NBINS; b++)
      chk($sformatf("%s_bin%0d", tag, b), 32'(bin_mem[b]), 32'(exp_bins[b]));
  endtask

  initial begin
    int sel;
    for (int b = 0; b < NBINS; b++) preset[b] = '0;
    for (int i = 0; i < (1 << PAW); i++) pix_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({valid, bin_wen, pix_raddr, bin_raddr, bin_waddr, bin_wdata}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outputs", 32'({valid, bin_wen, pix_raddr, bin_raddr, bin_waddr, bin_wdata}), 32'd0);

    // Distinct bins 0..7, start re-asserted (with clear) mid-run must be ignored
    preset_random();
    for (int i = 0; i < NP; i++) pix_mem[i] = pix_of_bin(i);
    run_check(1'b0, 1'b1, "distinct");

    // Same bin on every pixel: forwarding every cycle
    preset_const(0);
    for (int i = 0; i < NP; i++) pix_mem[i] = pix_of_bin(5);
    run_check(1'b0, 1'b0, "same5");

    // 3,3,4,3 then unrelated bins: forwarding only on matching bins
    preset_random();
    pix_mem[0] = pix_of_bin(3);
    pix_mem[1] = pix_of_bin(3);
    pix_mem[2] = pix_of_bin(4);
    pix_mem[3] = pix_of_bin(3);
    for (int i = 4; i < NP; i++) pix_mem[i] = pix_of_bin(i + 5);
    run_check(1'b0, 1'b0, "alt343");

    // Clear phase over a fully saturated RAM
    preset_const(BMAX);
    for (int i = 0; i < NP; i++) pix_mem[i] = PW'($urandom_range(0, (1 << PW) - 1));
    run_check(1'b1, 1'b0, "clear");

    // Bin at 14 hit three times: saturates at 15 or wraps to 1
    preset_random();
    preset[7] = BW'(14);
    load_bins();
    for (int i = 0; i < NP; i++) begin
      sel = $urandom_range(0, 3);
      pix_mem[i] = pix_of_bin((sel == 3) ? 8 : sel);
    end
    pix_mem[0] = pix_of_bin(7);
    pix_mem[1] = pix_of_bin(7);
    pix_mem[5] = pix_of_bin(7);
    run_check(1'b0, 1'b0, "sat14");

    // Random runs, back-to-back from DONE; narrow bin range forces collisions
    for (int r = 0; r < 4; r++) begin
      preset_random();
      for (int i = 0; i < NP; i++)
        pix_mem[i] = (r[0]) ? pix_of_bin($urandom_range(2, 3))
                            : PW'($urandom_range(0, (1 << PW) - 1));
      run_check(r == 2, 1'b0, $sformatf("rand%0d", r));
    end

    // Reset in the middle of RUN
    preset_random();
    for (int i = 0; i < NP; i++) pix_mem[i] = PW'($urandom_range(0, (1 << PW) - 1));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_wen", 32'(bin_wen), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_outputs", 32'({valid, bin_wen, pix_raddr, bin_raddr, bin_waddr, bin_wdata}), 32'd0);
    sel = wr_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_writes", 32'(wr_cnt - sel), 32'd0);
    chk("rst_valid_low", 32'(valid), 32'd0);
    for (int i = 0; i < NP; i++) pix_mem[i] = PW'($urandom_range(0, (1 << PW) - 1));
    run_check(1'b1, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
